sram_mem_responder: RTL

//  Responder side of the MEM-stage data-memory interface. Accepts one 32-bit read/write per request from the

---
 rtl/arm_mem_pkg.sv | 5 +
 rtl/sram_wait_counter.sv | 21 ++
 rtl/sram_mem_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory responder.
package arm_mem_pkg;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} mem_state_t;
  localparam int ADDR_BASE_DEF = 1024;
endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait counter: clears on demand, flags the last cycle of a phase.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  output logic [3:0] o_cnt,
  output logic       o_term
);
  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else            r_cnt <= r_cnt + 4'd1;
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == 4'(WAIT_CYCLES - 1));
endmodule

// File: rtl/sram_mem_responder.sv
// MEM-stage responder: one 32-bit access becomes two 16-bit async-SRAM phases,
// with ready low for the whole transaction so the pipeline freezes.
module sram_mem_responder
  import arm_mem_pkg::*;
#(
  parameter int ADDR_BASE   = ADDR_BASE_DEF,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_rd_en,
  input  logic               mem_wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
);
  mem_state_t         r_state;
  logic               r_is_wr;
  logic [SRAM_AW-2:0] r_idx;
  logic [15:0]        r_whi;

  logic               w_req;
  logic [SRAM_AW-2:0] w_idx;
  logic [3:0]         w_cnt;
  logic               w_term;
  logic               w_clr;
  logic               w_pre_last;

  assign w_req      = mem_rd_en | mem_wr_en;
  // Word index wraps silently: out-of-range addresses alias into the SRAM.
  assign w_idx      = (SRAM_AW-1)'((address - 32'(ADDR_BASE)) >> 2);
  assign w_clr      = (r_state == IDLE) || (r_state == DONE) || w_term;
  assign w_pre_last = (w_cnt == 4'(WAIT_CYCLES - 2));

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_clr),
    .o_cnt   (w_cnt),
    .o_term  (w_term)
  );

  always_comb begin
    ready = 1'b0;
    case (r_state)
      IDLE:    ready = ~w_req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Strobe rises one cycle before each phase ends so address/data are held past it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_is_wr     <= 1'b0;
      r_idx       <= '0;
      r_whi       <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (w_req) begin
          r_state    <= LO;
          r_is_wr    <= mem_wr_en;
          r_idx      <= w_idx;
          r_whi      <= wdata[31:16];
          sram_addr  <= {w_idx, 1'b0};
          sram_dq_oe <= mem_wr_en;
          sram_we_n  <= ~mem_wr_en;
          if (mem_wr_en) sram_dq_out <= wdata[15:0];
        end
        LO: begin
          if (w_term) begin
            r_state   <= HI;
            sram_addr <= {r_idx, 1'b1};
            sram_we_n <= ~r_is_wr;
            if (r_is_wr) sram_dq_out <= r_whi;
            else         rdata[15:0] <= sram_dq_in;
          end else if (w_pre_last) begin
            sram_we_n <= 1'b1;
          end
        end
        HI: begin
          if (w_term) begin
            r_state    <= DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!r_is_wr) rdata[31:16] <= sram_dq_in;
          end else if (w_pre_last) begin
            sram_we_n <= 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
